// File: rtl/riscv_prefetch_fetch_pkg.sv
// Shared definitions for the prefetching fetch stage: retire-length encodings,
// the FIFO entry layout and RVC length detection.
package riscv_prefetch_fetch_pkg;

    localparam logic [1:0] RETIRE_LEN_NONE = 2'd0;
    localparam logic [1:0] RETIRE_LEN_HALF = 2'd1;
    localparam logic [1:0] RETIRE_LEN_WORD = 2'd2;

    // One aligned instruction-memory word, split into its two parcels.
    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
    } fetch_entry_t;

    // A parcel whose two low bits are not 2'b11 starts a 16-bit instruction.
    function automatic logic is_compressed(input logic [1:0] opcode);
        return opcode != 2'b11;
    endfunction

endpackage

// File: rtl/riscv_prefetch_fetch_sync_fifo.sv
// Synchronous FIFO with flush and a two-entry look-ahead (head and head+1).
module riscv_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         peek0,
    output logic [WIDTH-1:0]         peek1,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage array; contents are only meaningful below level, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap modulo DEPTH; level runs 0..DEPTH; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    assign peek0 = mem[rd_ptr];
    assign peek1 = mem[rd_ptr + PTR_ONE];

endmodule

// File: rtl/riscv_prefetch_fetch.sv
// Prefetching fetch stage: issues word requests into a small FIFO and aligns
// 16/32-bit instructions across word boundaries for the decoder.
module riscv_prefetch_fetch
    import riscv_prefetch_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    WORD_WIDTH    = 32,
    parameter int                    DEPTH         = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR     = '0,
    parameter bit                    COMPRESSED_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_i,
    input  logic [ADDR_WIDTH-1:0]    target_addr_i,
    input  logic                     target_valid_i,
    input  logic [1:0]               retired_inst_len_i,
    output logic [31:0]              instr_o,
    output logic [ADDR_WIDTH-1:0]    instr_addr_o,
    output logic                     instr_valid_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     imem_valid_o,
    input  logic                     imem_ready_i,
    output logic [ADDR_WIDTH-1:0]    imem_addr_o,
    output logic [31:0]              imem_wdata_o,
    output logic [3:0]               imem_we_o,
    input  logic [31:0]              imem_rdata_i
);

    localparam int LW = $clog2(DEPTH) + 1;

    if (WORD_WIDTH != 32) begin : g_word_width_check
        $error("riscv_prefetch_fetch: WORD_WIDTH must be 32");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("riscv_prefetch_fetch: DEPTH must be a power of 2 and >= 2");
    end

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  pending;
    logic                  discard;
    logic [LW-1:0]         level;
    fetch_entry_t          head;
    fetch_entry_t          next;
    fetch_entry_t          assembled;
    logic                  issue;
    logic                  handshake;
    logic                  push;
    logic                  pop;
    logic                  pc_hi;
    logic                  head_rvc;
    logic                  need_two;

    assign issue        = req_i && !pending && (level < LW'(DEPTH));
    assign imem_valid_o = !rst && (pending || issue);
    assign handshake    = imem_valid_o && imem_ready_i;
    assign imem_addr_o  = imem_valid_o ? (pending ? req_addr : fetch_addr) : '0;
    assign imem_wdata_o = '0;
    assign imem_we_o    = '0;

    // Responses are dropped while a stale request drains or when a redirect lands.
    assign push = handshake && !discard && !target_valid_i;

    // Request tracking: a visible request is held until accepted, even across redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= 1'b0;
            discard    <= 1'b0;
            fetch_addr <= BOOT_ADDR;
            req_addr   <= BOOT_ADDR;
        end else begin
            if (handshake) begin
                pending <= 1'b0;
            end else if (imem_valid_o) begin
                pending <= 1'b1;
                if (!pending) req_addr <= fetch_addr;
            end

            if (target_valid_i) begin
                fetch_addr <= {target_addr_i[ADDR_WIDTH-1:2], 2'b00};
                discard    <= imem_valid_o && !imem_ready_i;
            end else if (handshake) begin
                if (discard) discard    <= 1'b0;
                else         fetch_addr <= fetch_addr + ADDR_WIDTH'(4);
            end
        end
    end

    riscv_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (target_valid_i),
        .wdata (imem_rdata_i),
        .peek0 (head),
        .peek1 (next),
        .level (level)
    );

    assign pc_hi    = COMPRESSED_EN && pc[1];
    assign head_rvc = is_compressed(head.hi[1:0]);
    assign need_two = pc_hi && !head_rvc;

    // Aligner: pick the parcel(s) at pc and decide whether they are all present.
    always_comb begin
        assembled = head;
        if (pc_hi) begin
            assembled.lo = head.hi;
            assembled.hi = head_rvc ? 16'h0000 : next.lo;
        end
        instr_valid_o = need_two ? (level >= LW'(2)) : (level >= LW'(1));
        instr_o       = instr_valid_o ? assembled : '0;
    end

    // A retire crossing into the next word frees the head entry.
    assign pop = instr_valid_o && !target_valid_i &&
                 ((pc_hi && retired_inst_len_i != RETIRE_LEN_NONE) ||
                  (retired_inst_len_i == RETIRE_LEN_WORD));

    // Program counter: redirect beats retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= BOOT_ADDR;
        end else if (target_valid_i) begin
            pc <= {target_addr_i[ADDR_WIDTH-1:2], target_addr_i[1] & COMPRESSED_EN, 1'b0};
        end else if (instr_valid_o) begin
            pc <= pc + ADDR_WIDTH'({retired_inst_len_i, 1'b0});
        end
    end

    assign instr_addr_o = pc;
    assign fifo_level_o = level;

    logic unused_bits;
    assign unused_bits = ^{target_addr_i[0], next.hi};

    // Consumer contract and internal invariant checks.
    a_retire_needs_valid: assert property (@(posedge clk) disable iff (rst)
        retired_inst_len_i != RETIRE_LEN_NONE |-> instr_valid_o);
    a_retire_len_legal: assert property (@(posedge clk) disable iff (rst)
        retired_inst_len_i != 2'd3);
    a_no_half_without_rvc: assert property (@(posedge clk) disable iff (rst)
        !COMPRESSED_EN |-> retired_inst_len_i != RETIRE_LEN_HALF);
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        push |-> level < LW'(DEPTH));

endmodule

// File: tb/tb_riscv_prefetch_fetch.sv
module tb_riscv_prefetch_fetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [31:0] target_addr_i;
    logic        target_valid_i;
    logic [1:0]  retired_inst_len_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_valid_o;
    logic [2:0]  fifo_level_o;
    logic        imem_valid_o;
    logic        imem_ready_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic [3:0]  imem_we_o;
    logic [31:0] imem_rdata_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_prefetch_fetch #(
        .ADDR_WIDTH    (32),
        .WORD_WIDTH    (32),
        .DEPTH         (DEPTH),
        .BOOT_ADDR     (BOOT),
        .COMPRESSED_EN (1'b1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_i              (req_i),
        .target_addr_i      (target_addr_i),
        .target_valid_i     (target_valid_i),
        .retired_inst_len_i (retired_inst_len_i),
        .instr_o            (instr_o),
        .instr_addr_o       (instr_addr_o),
        .instr_valid_o      (instr_valid_o),
        .fifo_level_o       (fifo_level_o),
        .imem_valid_o       (imem_valid_o),
        .imem_ready_i       (imem_ready_i),
        .imem_addr_o        (imem_addr_o),
        .imem_wdata_o       (imem_wdata_o),
        .imem_we_o          (imem_we_o),
        .imem_rdata_i       (imem_rdata_i)
    );

    // Instruction memory image, 4 KiB aliased over the address space.
    logic [31:0] mem_img [0:1023];
    assign imem_rdata_i = mem_img[imem_addr_o[11:2]];

    // Reference model: program counter, next word to fetch, words held,
    // and the outstanding request as seen from the imem port.
    logic [31:0] m_pc, m_fetch, m_out_addr;
    int          m_cnt;
    logic        m_out, m_discard;

    logic        e_imem_valid, e_instr_valid;
    logic [31:0] e_imem_addr, e_instr;
    logic [1:0]  e_len;

    function automatic logic [15:0] memh(input logic [31:0] a);
        logic [31:0] w;
        w = mem_img[a[11:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic model_reset();
        m_pc = BOOT; m_fetch = BOOT; m_out_addr = BOOT;
        m_cnt = 0; m_out = 1'b0; m_discard = 1'b0;
    endtask

    task automatic model_eval(input logic req);
        logic [15:0] h0;
        logic        rvc;
        int          need;
        h0  = memh(m_pc);
        rvc = (h0[1:0] != 2'b11);
        if (!m_pc[1])  begin e_instr = mem_img[m_pc[11:2]];       need = 1; end
        else if (rvc)  begin e_instr = {16'h0000, h0};            need = 1; end
        else           begin e_instr = {memh(m_pc + 32'd2), h0};  need = 2; end
        e_instr_valid = (m_cnt >= need);
        if (!e_instr_valid) e_instr = '0;
        e_len        = rvc ? 2'd1 : 2'd2;
        e_imem_valid = m_out || (req && m_cnt < DEPTH);
        e_imem_addr  = m_out ? m_out_addr : m_fetch;
    endtask

    task automatic model_update();
        logic hs;
        logic do_pop;
        hs = e_imem_valid && imem_ready_i;
        if (target_valid_i) begin
            if (e_imem_valid && !imem_ready_i) begin
                if (!m_out) m_out_addr = m_fetch;
                m_out = 1'b1; m_discard = 1'b1;
            end else begin
                m_out = 1'b0; m_discard = 1'b0;
            end
            m_cnt   = 0;
            m_pc    = {target_addr_i[31:1], 1'b0};
            m_fetch = {target_addr_i[31:2], 2'b00};
        end else begin
            do_pop = (retired_inst_len_i != 2'd0) && (m_pc[1] || retired_inst_len_i == 2'd2);
            if (hs) begin
                m_out = 1'b0;
                if (m_discard) m_discard = 1'b0;
                else begin m_cnt++; m_fetch += 32'd4; end
            end else if (e_imem_valid && !m_out) begin
                m_out = 1'b1; m_out_addr = m_fetch;
            end
            if (do_pop) m_cnt--;
            m_pc += 32'(retired_inst_len_i) * 32'd2;
        end
    endtask

    // len < 0: retire the correct length whenever the model says an instruction is ready.
    task automatic drive(input logic req, input logic rdy, input int len,
                         input logic tv, input logic [31:0] ta);
        model_eval(req);
        req_i          = req;
        imem_ready_i   = rdy;
        target_valid_i = tv;
        target_addr_i  = ta;
        if (len < 0) retired_inst_len_i = e_instr_valid ? e_len : 2'd0;
        else         retired_inst_len_i = len[1:0];
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic fill_mem(input bit only32);
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (only32 || $urandom_range(1) == 1) w[1:0]   = 2'b11; else w[1:0]   = 2'($urandom_range(2));
            if (only32 || $urandom_range(1) == 1) w[17:16] = 2'b11; else w[17:16] = 2'($urandom_range(2));
            mem_img[i] = w;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 0, 0, 32'h0);
        tick();
        checks++; if (imem_valid_o !== 1'b0)   begin failures++; $display("FAIL reset_imem_valid got=%0h exp=0", imem_valid_o); end
        checks++; if (instr_valid_o !== 1'b0)  begin failures++; $display("FAIL reset_instr_valid got=%0h exp=0", instr_valid_o); end
        checks++; if (instr_o !== 32'h0)       begin failures++; $display("FAIL reset_instr got=%h exp=0", instr_o); end
        checks++; if (instr_addr_o !== BOOT)   begin failures++; $display("FAIL reset_instr_addr got=%h exp=%h", instr_addr_o, BOOT); end
        checks++; if (fifo_level_o !== 3'd0)   begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level_o); end
        checks++; if (imem_addr_o !== 32'h0)   begin failures++; $display("FAIL reset_imem_addr got=%h exp=0", imem_addr_o); end
        checks++; if (imem_wdata_o !== 32'h0 || imem_we_o !== 4'h0) begin failures++; $display("FAIL reset_write_ties got=%h/%h exp=0/0", imem_wdata_o, imem_we_o); end
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (imem_valid_o !== 1'b0)   begin failures++; $display("FAIL post_reset_idle got=%0h exp=0", imem_valid_o); end
        tick();
    endtask

    task automatic test_sequential();
        int          hs_k;
        int          v_k;
        fill_mem(1'b1);
        do_reset();
        hs_k = 0; v_k = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1, 1, -1, 0, 32'h0);
            if (imem_valid_o && imem_ready_i) begin
                checks++; if (imem_addr_o !== BOOT + 32'(4 * hs_k)) begin failures++; $display("FAIL seq_imem_addr got=%h exp=%h", imem_addr_o, BOOT + 32'(4 * hs_k)); end
                hs_k++;
            end
            checks++; if (instr_valid_o !== (c >= 1)) begin failures++; $display("FAIL seq_instr_valid cyc=%0d got=%0h exp=%0h", c, instr_valid_o, (c >= 1)); end
            if (c >= 1) begin
                checks++; if (instr_addr_o !== BOOT + 32'(4 * v_k)) begin failures++; $display("FAIL seq_instr_addr got=%h exp=%h", instr_addr_o, BOOT + 32'(4 * v_k)); end
                checks++; if (instr_o !== e_instr) begin failures++; $display("FAIL seq_instr got=%h exp=%h", instr_o, e_instr); end
                v_k++;
            end
            tick();
        end
    endtask

    task automatic test_compressed();
        fill_mem(1'b1);
        mem_img[BOOT[11:2]] = 32'h0001_4501;
        do_reset();
        drive(1, 1, 0, 0, 32'h0);
        tick();
        drive(0, 0, 1, 0, 32'h0);
        checks++; if (instr_valid_o !== 1'b1 || instr_o[15:0] !== 16'h4501) begin failures++; $display("FAIL rvc_first got=%0h/%h exp=1/4501", instr_valid_o, instr_o[15:0]); end
        checks++; if (instr_addr_o !== 32'h100) begin failures++; $display("FAIL rvc_first_pc got=%h exp=100", instr_addr_o); end
        tick();
        drive(0, 0, 1, 0, 32'h0);
        checks++; if (fifo_level_o !== 3'd1) begin failures++; $display("FAIL rvc_no_pop got=%0d exp=1", fifo_level_o); end
        checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_0001) begin failures++; $display("FAIL rvc_second got=%0h/%h exp=1/00000001", instr_valid_o, instr_o); end
        checks++; if (instr_addr_o !== 32'h102) begin failures++; $display("FAIL rvc_second_pc got=%h exp=102", instr_addr_o); end
        tick();
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (fifo_level_o !== 3'd0 || instr_addr_o !== 32'h104) begin failures++; $display("FAIL rvc_one_pop got=%0d/%h exp=0/104", fifo_level_o, instr_addr_o); end
        tick();
    endtask

    task automatic test_misaligned();
        fill_mem(1'b1);
        mem_img[BOOT[11:2]]     = 32'h0513_1234;
        mem_img[BOOT[11:2] + 1] = 32'hABCD_0000;
        do_reset();
        drive(0, 0, 0, 1, 32'h102);
        tick();
        drive(1, 1, 0, 0, 32'h0);
        checks++; if (imem_addr_o !== 32'h100) begin failures++; $display("FAIL mis_fetch_addr got=%h exp=100", imem_addr_o); end
        tick();
        drive(1, 1, 0, 0, 32'h0);
        checks++; if (fifo_level_o !== 3'd1 || instr_valid_o !== 1'b0) begin failures++; $display("FAIL mis_wait_level2 got=%0d/%0h exp=1/0", fifo_level_o, instr_valid_o); end
        tick();
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_0513) begin failures++; $display("FAIL mis_instr got=%0h/%h exp=1/00000513", instr_valid_o, instr_o); end
        checks++; if (instr_addr_o !== 32'h102) begin failures++; $display("FAIL mis_pc got=%h exp=102", instr_addr_o); end
        tick();
    endtask

    task automatic test_full();
        int hs_n;
        fill_mem(1'b1);
        do_reset();
        hs_n = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1, 1, 0, 0, 32'h0);
            if (imem_valid_o && imem_ready_i) hs_n++;
            tick();
        end
        drive(1, 1, 0, 0, 32'h0);
        checks++; if (hs_n !== 4) begin failures++; $display("FAIL full_req_count got=%0d exp=4", hs_n); end
        checks++; if (imem_valid_o !== 1'b0 || fifo_level_o !== 3'd4) begin failures++; $display("FAIL full_stall got=%0h/%0d exp=0/4", imem_valid_o, fifo_level_o); end
        drive(1, 1, 2, 0, 32'h0);
        tick();
        drive(1, 1, 0, 0, 32'h0);
        checks++; if (imem_valid_o !== 1'b1 || fifo_level_o !== 3'd3) begin failures++; $display("FAIL full_resume got=%0h/%0d exp=1/3", imem_valid_o, fifo_level_o); end
        tick();
    endtask

    task automatic test_redirect_pending();
        fill_mem(1'b1);
        mem_img[0] = 32'h4505_1111;
        do_reset();
        drive(1, 0, 0, 0, 32'h0);
        tick();
        drive(1, 0, 0, 1, 32'h2002);
        checks++; if (imem_valid_o !== 1'b1 || imem_addr_o !== 32'h100) begin failures++; $display("FAIL redir_hold_a got=%0h/%h exp=1/100", imem_valid_o, imem_addr_o); end
        tick();
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (imem_valid_o !== 1'b1 || imem_addr_o !== 32'h100) begin failures++; $display("FAIL redir_hold_b got=%0h/%h exp=1/100", imem_valid_o, imem_addr_o); end
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL redir_valid_after got=%0h exp=0", instr_valid_o); end
        tick();
        drive(1, 1, 0, 0, 32'h0);
        tick();
        drive(1, 1, 0, 0, 32'h0);
        checks++; if (fifo_level_o !== 3'd0) begin failures++; $display("FAIL redir_stale_dropped got=%0d exp=0", fifo_level_o); end
        checks++; if (imem_valid_o !== 1'b1 || imem_addr_o !== 32'h2000) begin failures++; $display("FAIL redir_new_addr got=%0h/%h exp=1/2000", imem_valid_o, imem_addr_o); end
        tick();
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (instr_valid_o !== 1'b1 || instr_addr_o !== 32'h2002 || instr_o !== 32'h0000_4505) begin failures++; $display("FAIL redir_instr got=%0h/%h/%h exp=1/2002/00004505", instr_valid_o, instr_addr_o, instr_o); end
        tick();
    endtask

    task automatic test_same_cycle();
        fill_mem(1'b1);
        do_reset();
        drive(1, 1, 0, 0, 32'h0);
        tick();
        drive(1, 0, 0, 0, 32'h0);
        tick();
        drive(1, 1, 2, 1, 32'h300);
        checks++; if (instr_valid_o !== 1'b1) begin failures++; $display("FAIL same_pre_valid got=%0h exp=1", instr_valid_o); end
        tick();
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (fifo_level_o !== 3'd0 || instr_addr_o !== 32'h300) begin failures++; $display("FAIL same_flush got=%0d/%h exp=0/300", fifo_level_o, instr_addr_o); end
        checks++; if (imem_valid_o !== 1'b0) begin failures++; $display("FAIL same_no_pending got=%0h exp=0", imem_valid_o); end
        tick();
        drive(1, 1, 0, 0, 32'h0);
        checks++; if (imem_addr_o !== 32'h300) begin failures++; $display("FAIL same_next_addr got=%h exp=300", imem_addr_o); end
        tick();
        drive(0, 0, 0, 0, 32'h0);
        checks++; if (fifo_level_o !== 3'd1) begin failures++; $display("FAIL same_refill got=%0d exp=1", fifo_level_o); end
        tick();
    endtask

    task automatic test_random();
        logic        req, rdy, tv;
        logic [31:0] ta;
        int          len;
        fill_mem(1'b0);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req = ($urandom_range(9) < 8);
            rdy = ($urandom_range(9) < 6);
            tv  = ($urandom_range(15) == 0);
            ta  = 32'($urandom_range(2047)) * 32'd2;
            len = ($urandom_range(9) < 7) ? -1 : 0;
            drive(req, rdy, len, tv, ta);
            checks++; if (imem_valid_o !== e_imem_valid) begin failures++; $display("FAIL rnd_imem_valid cyc=%0d got=%0h exp=%0h", c, imem_valid_o, e_imem_valid); end
            if (e_imem_valid) begin
                checks++; if (imem_addr_o !== e_imem_addr) begin failures++; $display("FAIL rnd_imem_addr cyc=%0d got=%h exp=%h", c, imem_addr_o, e_imem_addr); end
            end
            checks++; if (instr_valid_o !== e_instr_valid) begin failures++; $display("FAIL rnd_instr_valid cyc=%0d got=%0h exp=%0h", c, instr_valid_o, e_instr_valid); end
            checks++; if (instr_o !== e_instr) begin failures++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", c, instr_o, e_instr); end
            checks++; if (instr_addr_o !== m_pc) begin failures++; $display("FAIL rnd_instr_addr cyc=%0d got=%h exp=%h", c, instr_addr_o, m_pc); end
            checks++; if (32'(fifo_level_o) !== 32'(m_cnt)) begin failures++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", c, fifo_level_o, m_cnt); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; imem_ready_i = 1'b0; target_valid_i = 1'b0;
        target_addr_i = '0; retired_inst_len_i = '0;
        for (int i = 0; i < 1024; i++) mem_img[i] = 32'h0;
        model_reset();
        test_reset();
        test_sequential();
        test_compressed();
        test_misaligned();
        test_full();
        test_redirect_pending();
        test_same_cycle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
